alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences single arithmetic/branch requests through an external combinational ALU.
// One request in flight: IDLE accepts, EXEC samples the ALU, RESP holds the result until taken.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_branch,
    input  logic [2:0]       req_op,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [2:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_w,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_taken,
    output logic             rsp_error,
    output logic [CNT_W-1:0] cnt_ops,
    output logic [CNT_W-1:0] cnt_taken
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic        is_branch;
        logic [2:0]  op;
        logic [2:0]  funct3;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd4;
    localparam logic [2:0] OP_SLTU = 3'd5;

    state_t state, state_nx;
    req_t   lat;
    logic   illegal;
    logic   taken_c;
    logic   hs;

    // SLT/SLTU already deliver the comparison in bit 0, so the sign flag drives no decision.
    logic unused_flags;
    assign unused_flags = alu_sign;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Illegal requests still occupy the ALU, but as a harmless ADD.
    always_comb begin
        illegal = 1'b0;
        alu_op  = OP_ADD;
        if (lat.is_branch) begin
            case (lat.funct3)
                3'b000, 3'b001: alu_op = OP_SUB;
                3'b100, 3'b101: alu_op = OP_SLT;
                3'b110, 3'b111: alu_op = OP_SLTU;
                default:        illegal = 1'b1;
            endcase
        end else if (lat.op == 3'd7) begin
            illegal = 1'b1;
        end else begin
            alu_op = lat.op;
        end
    end

    always_comb begin
        taken_c = 1'b0;
        if (lat.is_branch) begin
            case (lat.funct3)
                3'b000:         taken_c = alu_zero;
                3'b001:         taken_c = ~alu_zero;
                3'b100, 3'b110: taken_c = alu_w[0];
                3'b101, 3'b111: taken_c = ~alu_w[0];
                default:        taken_c = 1'b0;
            endcase
        end
    end

    assign alu_a = lat.a;
    assign alu_b = lat.b;
    assign hs    = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat        <= '0;
            rsp_result <= '0;
            rsp_taken  <= 1'b0;
            rsp_error  <= 1'b0;
            cnt_ops    <= '0;
            cnt_taken  <= '0;
        end else begin
            if (state == IDLE && req_valid)
                lat <= '{req_is_branch, req_op, req_funct3, req_a, req_b};
            if (state == EXEC) begin
                rsp_result <= illegal ? 32'd0 : alu_w;
                rsp_taken  <= taken_c;
                rsp_error  <= illegal;
            end
            if (hs && !rsp_error && cnt_ops != '1)
                cnt_ops <= cnt_ops + CNT_W'(1);
            if (hs && rsp_taken && cnt_taken != '1)
                cnt_taken <= cnt_taken + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed table, multi-cycle corner sequences, then random traffic.
// A CNT_W=2 instance shares the stimulus so counter saturation is checked alongside.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_branch, rsp_ready;
    logic [2:0]  req_op, req_funct3;
    logic [31:0] req_a, req_b;

    logic        req_ready, rsp_valid, rsp_taken, rsp_error, alu_zero, alu_sign;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_w, rsp_result;
    logic [15:0] cnt_ops, cnt_taken;

    logic        s_req_ready, s_rsp_valid, s_rsp_taken, s_rsp_error, s_alu_zero, s_alu_sign;
    logic [2:0]  s_alu_op;
    logic [31:0] s_alu_a, s_alu_b, s_alu_w, s_rsp_result;
    logic [1:0]  s_cnt_ops, s_cnt_taken;

    int nvec = 0;
    int nerr = 0;
    int m_ops = 0;
    int m_taken = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            3'd6: return a ^ b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign alu_w      = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_w == 32'd0);
    assign alu_sign   = alu_w[31];
    assign s_alu_w    = alu_f(s_alu_op, s_alu_a, s_alu_b);
    assign s_alu_zero = (s_alu_w == 32'd0);
    assign s_alu_sign = s_alu_w[31];

    alu_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_branch(req_is_branch), .req_op(req_op), .req_funct3(req_funct3),
        .req_a(req_a), .req_b(req_b), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_w(alu_w), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_taken(rsp_taken), .rsp_error(rsp_error), .cnt_ops(cnt_ops), .cnt_taken(cnt_taken)
    );

    alu_sequencer #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_is_branch(req_is_branch), .req_op(req_op), .req_funct3(req_funct3),
        .req_a(req_a), .req_b(req_b), .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b),
        .alu_w(s_alu_w), .alu_zero(s_alu_zero), .alu_sign(s_alu_sign),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
        .rsp_taken(s_rsp_taken), .rsp_error(s_rsp_error), .cnt_ops(s_cnt_ops), .cnt_taken(s_cnt_taken)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: branch outcomes come straight from operand comparisons.
    task automatic model(input logic br, input logic [2:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic tk, output logic er,
                         output logic [2:0] aop);
        logic lt, ult;
        lt  = $signed(a) < $signed(b);
        ult = a < b;
        res = 32'd0; tk = 1'b0; er = 1'b0; aop = 3'd0;
        if (!br) begin
            if (op == 3'd7) er = 1'b1;
            else begin res = alu_f(op, a, b); aop = op; end
        end else begin
            case (f3)
                3'b000: begin res = a - b; tk = (a == b); aop = 3'd1; end
                3'b001: begin res = a - b; tk = (a != b); aop = 3'd1; end
                3'b100: begin res = {31'd0, lt};  tk = lt;   aop = 3'd4; end
                3'b101: begin res = {31'd0, lt};  tk = !lt;  aop = 3'd4; end
                3'b110: begin res = {31'd0, ult}; tk = ult;  aop = 3'd5; end
                3'b111: begin res = {31'd0, ult}; tk = !ult; aop = 3'd5; end
                default: er = 1'b1;
            endcase
        end
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_cnt_ops"},     32'(cnt_ops),     32'((m_ops   > 65535) ? 65535 : m_ops));
        chk({tag, "_cnt_taken"},   32'(cnt_taken),   32'((m_taken > 65535) ? 65535 : m_taken));
        chk({tag, "_s_cnt_ops"},   32'(s_cnt_ops),   32'((m_ops   > 3) ? 3 : m_ops));
        chk({tag, "_s_cnt_taken"}, 32'(s_cnt_taken), 32'((m_taken > 3) ? 3 : m_taken));
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input logic br, input logic [2:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic et, input logic ee,
                          input int stall, input bit inject);
        logic [31:0] mres;
        logic        mt, me;
        logic [2:0]  maop;
        model(br, op, f3, a, b, mres, mt, me, maop);
        chk("idle_req_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_is_branch = br; req_op = op; req_funct3 = f3;
        req_a = a; req_b = b; rsp_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_a = ~a; req_b = ~b;
        chk("exec_rsp_valid", 32'(rsp_valid), 0);
        chk("exec_req_ready", 32'(req_ready), 0);
        chk("exec_alu_op", 32'(alu_op), 32'(maop));
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        @(posedge clk); @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_result", rsp_result, er);
        chk("rsp_taken", 32'(rsp_taken), 32'(et));
        chk("rsp_error", 32'(rsp_error), 32'(ee));
        if (inject) begin
            req_valid = 1'b1; req_is_branch = 1'b0; req_op = 3'd6; req_a = ~a; req_b = 32'd1;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 1);
            chk("hold_rsp_result", rsp_result, er);
            chk("hold_rsp_taken", 32'(rsp_taken), 32'(et));
            chk("hold_req_ready", 32'(req_ready), 0);
            chk("hold_alu_a", alu_a, a);
            chk_cnts("hold");
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        if (!ee) m_ops++;
        if (et)  m_taken++;
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        chk("post_req_ready", 32'(req_ready), 1);
        chk("post_rsp_result_held", rsp_result, er);
        chk_cnts("post");
    endtask

    task automatic run_model(input logic br, input logic [2:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] r;
        logic        t, e;
        logic [2:0]  ao;
        model(br, op, f3, a, b, r, t, e, ao);
        run_op(br, op, f3, a, b, r, t, e, stall, 1'b0);
    endtask

    typedef struct {
        logic        br;
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        tk;
        logic        er;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 3'd0,   32'd5,        32'd7,      32'd12,         1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd0, 3'b000, 32'h1234,     32'h1234,   32'd0,          1'b1, 1'b0};
        tbl[2]  = '{1'b1, 3'd0, 3'b001, 32'h1234,     32'h1234,   32'd0,          1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'd0, 3'b110, 32'd3,        32'd9,      32'd1,          1'b1, 1'b0};
        tbl[4]  = '{1'b1, 3'd0, 3'b111, 32'd3,        32'd9,      32'd1,          1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd7, 3'd0,   32'd1,        32'd2,      32'd0,          1'b0, 1'b1};
        tbl[6]  = '{1'b1, 3'd0, 3'b010, 32'd5,        32'd5,      32'd0,          1'b0, 1'b1};
        tbl[7]  = '{1'b0, 3'd1, 3'd0,   32'd3,        32'd5,      32'hFFFFFFFE,   1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd4, 3'd0,   32'hFFFFFFFF, 32'd1,      32'd1,          1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'd5, 3'd0,   32'hFFFFFFFF, 32'd1,      32'd0,          1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd6, 3'd0,   32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 3'd0, 3'b100, 32'hFFFFFFFB, 32'd2,      32'd1,          1'b1, 1'b0};
        tbl[12] = '{1'b1, 3'd0, 3'b101, 32'hFFFFFFFB, 32'd2,      32'd1,          1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'd0, 3'b011, 32'd8,        32'd1,      32'd0,          1'b0, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_is_branch = 1'b0; req_op = 3'd0; req_funct3 = 3'd0;
        req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_taken", 32'(rsp_taken), 0);
        chk("rst_rsp_error", 32'(rsp_error), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk_cnts("rst");

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].br, tbl[i].op, tbl[i].f3, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].tk, tbl[i].er, 0, 1'b0);
            if (i == 0) chk("add_cnt_ops_is_1", 32'(cnt_ops), 1);
            if (i == 4) chk("branches_cnt_taken_is_2", 32'(cnt_taken), 2);
        end

        // Backpressure with a competing request presented while the response is held.
        run_model(1'b0, 3'd0, 3'd0, 32'd100, 32'd23, 0);
        run_op(1'b0, 3'd3, 3'd0, 32'h0F00, 32'h00F0, 32'h0FF0, 1'b0, 1'b0, 10, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("bp_idle_after_rsp_valid", 32'(rsp_valid), 0);
        chk("bp_idle_after_req_ready", 32'(req_ready), 1);

        // Reset while the request is in EXEC: no response, counters cleared.
        req_valid = 1'b1; req_is_branch = 1'b0; req_op = 3'd0; req_a = 32'd1; req_b = 32'd2;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; m_ops = 0; m_taken = 0;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_req_ready", 32'(req_ready), 1);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_rsp_result", rsp_result, 0);
        chk_cnts("midrst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 0);
            chk_cnts("midrst_idle");
        end
        rsp_ready = 1'b0;

        // Five taken branches: the 2-bit instance must pin at 3.
        for (int i = 0; i < 5; i++)
            run_op(1'b1, 3'd0, 3'b000, 32'(i * 7), 32'(i * 7), 32'd0, 1'b1, 1'b0, 0, 1'b0);
        chk("sat_s_cnt_ops", 32'(s_cnt_ops), 3);
        chk("sat_s_cnt_taken", 32'(s_cnt_taken), 3);
        chk("sat_cnt_taken", 32'(cnt_taken), 5);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            run_model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
